ahb_mgr_if: RTL and testbench
=============================

Name: ahb_mgr_if

Overview:
AHB-Lite manager bridge that takes single-word requests on a cpuif-style client port (req/ack/stall, same signalling as the I3C CSR access interface) and issues AHB-Lite single transfers toward a subordinate. It is the initiator-side counterpart of the subordinate CSR bridge. It lets internal agents (DMA-like queue movers, test harness) reach AHB-mapped registers. One outstanding transfer at a time; no bursts.

Parameters:
AHB_DATA_WIDTH, 64, AHB data bus width; one of {32,64,128,256}. Elaboration error otherwise.
AHB_ADDR_WIDTH, 32, AHB address width; 10..64.
AHB_BURST_WIDTH, 3, hburst_o width; 0..3. A width of 0 means the port is absent.
CPUIF_ADDR_WIDTH, 12, client byte-address width; must be <= AHB_ADDR_WIDTH.
BASE_ADDR, 0, AHB_ADDR_WIDTH-bit offset added to the client address.

Ports:
hclk_i  in  1  clock
hreset_i  in  1  synchronous active-high reset
m_cpuif_req  in  1  client request valid; held until accepted
m_cpuif_req_is_wr  in  1  1=write, 0=read
m_cpuif_addr  in  CPUIF_ADDR_WIDTH  byte address
m_cpuif_wr_data  in  32  write data
m_cpuif_wr_biten  in  32  write bit enables
m_cpuif_req_stall_wr  out  1  write request not accepted this cycle
m_cpuif_req_stall_rd  out  1  read request not accepted this cycle
m_cpuif_rd_ack  out  1  read complete, one-cycle pulse
m_cpuif_rd_err  out  1  read error, valid with rd_ack
m_cpuif_rd_data  out  32  read data, valid with rd_ack, else 0
m_cpuif_wr_ack  out  1  write complete, one-cycle pulse
m_cpuif_wr_err  out  1  write error, valid with wr_ack
haddr_o  out  AHB_ADDR_WIDTH  transfer address
hburst_o  out  AHB_BURST_WIDTH  constant 0 (SINGLE)
hprot_o  out  4  constant 4'b0011 (data, privileged)
hsize_o  out  3  constant 3'b010 (word)
htrans_o  out  2  IDLE=2'b00 or NONSEQ=2'b10 only
hwdata_o  out  AHB_DATA_WIDTH  write data (data phase)
hwstrb_o  out  AHB_DATA_WIDTH/8  byte strobes (data phase)
hwrite_o  out  1  transfer direction
hrdata_i  in  AHB_DATA_WIDTH  read data
hready_i  in  1  bus ready
hresp_i  in  1  error response

Behaviour:
- Reset (sync, active-high): state=IDLE. htrans_o=IDLE. haddr_o, hwrite_o, hwdata_o, hwstrb_o, all acks/errs and rd_data are 0. Both stalls are 0.
- Reset asserted mid-transfer abandons it. No ack is issued afterwards, and htrans_o is IDLE the cycle after reset.
- FSM states:
  - IDLE: request accepted when m_cpuif_req=1. Capture is_wr, addr, wr_data, biten.
    - If addr[1:0]!=0, go to ERR. No AHB traffic.
    - Otherwise go to ADDR.
  - ADDR: htrans_o=NONSEQ.
    - haddr_o = BASE_ADDR + zero-extended addr.
    - hwrite_o = is_wr.
    - Hold all of these stable while hready_i=0. Go to DATA on hready_i=1.
  - DATA: htrans_o=IDLE.
    - Writes drive hwdata_o and hwstrb_o for the whole phase.
    - hready_i=0 with hresp_i=0: wait.
    - hready_i=0 with hresp_i=1: first error cycle; latch error flag and stay.
    - hready_i=1: completion. Go to RESP with err = hresp_i OR latched flag.
  - RESP: pulse rd_ack or wr_ack (per is_wr) with err, and rd_data for reads. Go to IDLE.
  - ERR: pulse the ack with err=1 and rd_data=0. Go to IDLE.
- Stalls: stall_wr = stall_rd = (state != IDLE). A request presented in IDLE is accepted in that cycle.
- Latency with zero wait states:
  - acceptance cycle N;
  - address phase N+1;
  - data phase N+2;
  - ack N+3.
  - Each wait state adds one cycle. The next request can be accepted at N+3 when the ack is high and state is IDLE in that same cycle.
- Lanes: let L = AHB_DATA_WIDTH/32 and lane = haddr_o[$clog2(AHB_DATA_WIDTH/8)-1:2]. For 32-bit width, lane=0.
  - hwdata_o replicates wr_data across all L lanes.
  - hwstrb_o is 0 except the selected lane's 4 bits. Bit b is the OR of biten[8b+7:8b].
  - rd_data = hrdata_i[lane*32 +: 32], sampled at DATA completion and registered into RESP.
  - Reads drive hwstrb_o=0.
- Writes with biten all zero are still issued, with hwstrb_o=0.
- haddr_o sum wraps modulo 2^AHB_ADDR_WIDTH.
- Exactly one of rd_ack/wr_ack pulses per accepted request; never both.

Test Plan:
1. Write to addr 0x104 with data 0xA5A5_1234, biten=all ones, BASE_ADDR=0x1000_0000, zero waits:
   - AHB addr phase: haddr_o=0x1000_0104, htrans_o=NONSEQ, hwrite_o=1.
   - Data phase: hwdata_o=0xA5A51234_A5A51234, hwstrb_o=8'hF0.
   - wr_ack=1, wr_err=0 three cycles after acceptance.
2. Read of addr 0x8 with hready_i low for 2 address-phase cycles and 3 data-phase cycles, hrdata_i=0xDEAD_BEEF_0BAD_F00D:
   - Address held stable throughout the stalls.
   - rd_data=0x0BAD_F00D, rd_ack at acceptance+8, stalls high throughout.
3. Write to addr 0x10; subordinate returns the two-cycle error response (hresp=1/hready=0, then hresp=1/hready=1) -> wr_ack=1, wr_err=1, htrans_o=IDLE during both error cycles.
4. Read of misaligned addr 0x6 -> no NONSEQ ever driven; rd_ack=1, rd_err=1, rd_data=0 one cycle after acceptance.
5. Back-to-back write then read with req held continuously -> the second request is accepted in the wr_ack cycle, and the second NONSEQ appears at the next cycle.
6. hreset_i asserted during DATA with hready_i=0 -> next cycle htrans_o=IDLE, all outputs 0, and no ack pulse follows.

Source files
------------

// File: rtl/ahb_mgr_if.sv
// -----------------------------------------------------------------------------
// ahb_mgr_if
//
// Purpose:
//   AHB-Lite manager bridge. It takes single 32-bit word requests from a
//   cpuif-style client port (req / ack / stall) and issues one AHB-Lite
//   SINGLE transfer per request. At most one transfer is outstanding. It is
//   the initiator-side counterpart of the subordinate CSR bridge, so internal
//   agents (queue movers, test harness) can reach AHB-mapped registers.
//
// Ports:
//   hclk_i / hreset_i      clock, synchronous active-high reset
//   m_cpuif_req*           client request: direction, byte address, data, bit
//                          enables; the request is held until accepted
//   m_cpuif_req_stall_*    high while a transfer is in flight (not IDLE)
//   m_cpuif_rd_*/wr_*      one-cycle completion pulse, error flag, read data
//   haddr_o .. hwrite_o    AHB-Lite manager outputs; hburst/hprot/hsize fixed
//   hrdata_i/hready_i/hresp_i  AHB-Lite subordinate responses
//
// Timing (zero wait states): accept at N, address phase N+1, data phase N+2,
// completion pulse at N+3. The completion is held in registers rather than in
// a separate FSM state, so the FSM is already back in IDLE during the pulse
// cycle and a held request is accepted in that same cycle. A misaligned
// request never reaches the bus; its error pulse appears at N+1.
//
// An AHB_BURST_WIDTH of 0 cannot be expressed as a zero-width port, so it
// yields a single tied-off hburst_o bit that integrators leave unconnected.
// -----------------------------------------------------------------------------
module ahb_mgr_if #(
  parameter int                        AHB_DATA_WIDTH   = 64,
  parameter int                        AHB_ADDR_WIDTH   = 32,
  parameter int                        AHB_BURST_WIDTH  = 3,
  parameter int                        CPUIF_ADDR_WIDTH = 12,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  localparam int BURST_W = (AHB_BURST_WIDTH > 0) ? AHB_BURST_WIDTH : 1
) (
  input  logic                          hclk_i,
  input  logic                          hreset_i,

  // Client (cpuif) port
  input  logic                          m_cpuif_req,
  input  logic                          m_cpuif_req_is_wr,
  input  logic [CPUIF_ADDR_WIDTH-1:0]   m_cpuif_addr,
  input  logic [31:0]                   m_cpuif_wr_data,
  input  logic [31:0]                   m_cpuif_wr_biten,
  output logic                          m_cpuif_req_stall_wr,
  output logic                          m_cpuif_req_stall_rd,
  output logic                          m_cpuif_rd_ack,
  output logic                          m_cpuif_rd_err,
  output logic [31:0]                   m_cpuif_rd_data,
  output logic                          m_cpuif_wr_ack,
  output logic                          m_cpuif_wr_err,

  // AHB-Lite manager port
  output logic [AHB_ADDR_WIDTH-1:0]     haddr_o,
  output logic [BURST_W-1:0]            hburst_o,
  output logic [3:0]                    hprot_o,
  output logic [2:0]                    hsize_o,
  output logic [1:0]                    htrans_o,
  output logic [AHB_DATA_WIDTH-1:0]     hwdata_o,
  output logic [AHB_DATA_WIDTH/8-1:0]   hwstrb_o,
  output logic                          hwrite_o,
  input  logic [AHB_DATA_WIDTH-1:0]     hrdata_i,
  input  logic                          hready_i,
  input  logic                          hresp_i
);

  // ---------------------------------------------------------------------------
  // Parameter legality (elaboration-time only)
  // ---------------------------------------------------------------------------
  if (!(AHB_DATA_WIDTH == 32 || AHB_DATA_WIDTH == 64 ||
        AHB_DATA_WIDTH == 128 || AHB_DATA_WIDTH == 256)) begin : g_bad_data_width
    $error("ahb_mgr_if: AHB_DATA_WIDTH must be 32, 64, 128 or 256");
  end
  if (AHB_ADDR_WIDTH < 10 || AHB_ADDR_WIDTH > 64) begin : g_bad_addr_width
    $error("ahb_mgr_if: AHB_ADDR_WIDTH must be in 10..64");
  end
  if (AHB_BURST_WIDTH < 0 || AHB_BURST_WIDTH > 3) begin : g_bad_burst_width
    $error("ahb_mgr_if: AHB_BURST_WIDTH must be in 0..3");
  end
  if (CPUIF_ADDR_WIDTH < 2 || CPUIF_ADDR_WIDTH > AHB_ADDR_WIDTH) begin : g_bad_cpuif_width
    $error("ahb_mgr_if: CPUIF_ADDR_WIDTH must be in 2..AHB_ADDR_WIDTH");
  end

  // Number of 32-bit lanes on the AHB data bus and the haddr bits that pick
  // one. For a 32-bit bus there is a single lane and the select is constant.
  localparam int LANES     = AHB_DATA_WIDTH / 32;
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // FSM encoding. Completion (RESP) and the misaligned error (ERR) are the
  // registered ack pulses below, not extra states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                state_q,   state_d;
  logic                      is_wr_q,   is_wr_d;
  logic [31:0]               wr_data_q, wr_data_d;
  logic [3:0]                byte_en_q, byte_en_d;  // biten folded to bytes
  logic [AHB_ADDR_WIDTH-1:0] haddr_q,   haddr_d;
  logic                      err_lat_q, err_lat_d;  // hresp seen during waits
  logic                      rd_ack_q,  rd_ack_d;
  logic                      wr_ack_q,  wr_ack_d;
  logic                      ack_err_q, ack_err_d;
  logic [31:0]               rd_data_q, rd_data_d;

  logic [3:0]                req_byte_en;
  logic [LANES-1:0]          lane_sel;
  logic [31:0]               lane_rdata;
  logic                      wr_data_phase;

  // A byte strobe is set if any enable bit inside that byte is set.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      req_byte_en[b] = |m_cpuif_wr_biten[8*b +: 8];
    end
  end

  // One-hot lane select from the word-within-beat address bits.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_sel[l] = (LANES == 1) ? 1'b1
                  : (haddr_q[2 +: LANE_BITS] == LANE_BITS'(l));
    end
  end

  always_comb begin
    lane_rdata = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_sel[l]) begin
        lane_rdata = lane_rdata | hrdata_i[l*32 +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    wr_data_d = wr_data_q;
    byte_en_d = byte_en_q;
    haddr_d   = haddr_q;
    err_lat_d = err_lat_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    ack_err_d = 1'b0;
    rd_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (m_cpuif_req) begin
          is_wr_d   = m_cpuif_req_is_wr;
          wr_data_d = m_cpuif_wr_data;
          byte_en_d = req_byte_en;
          err_lat_d = 1'b0;
          if (m_cpuif_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error at once, never touch the bus.
            rd_ack_d  = ~m_cpuif_req_is_wr;
            wr_ack_d  = m_cpuif_req_is_wr;
            ack_err_d = 1'b1;
          end else begin
            // Sum wraps naturally at AHB_ADDR_WIDTH bits.
            haddr_d = BASE_ADDR + AHB_ADDR_WIDTH'(m_cpuif_addr);
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (hready_i) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (hready_i) begin
          // Completion: the first error cycle (hready low) was latched, the
          // second one arrives here with hready high.
          state_d   = ST_IDLE;
          rd_ack_d  = ~is_wr_q;
          wr_ack_d  = is_wr_q;
          ack_err_d = hresp_i | err_lat_q;
          if (!is_wr_q) begin
            rd_data_d = lane_rdata;
          end
        end else if (hresp_i) begin
          err_lat_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (synchronous reset; abandons any transfer in flight)
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk_i) begin
    // NOTE: non-blocking assignments here, so every flop samples the values
    // from before this edge regardless of statement order.
    if (hreset_i) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      wr_data_q <= '0;
      byte_en_q <= '0;
      haddr_q   <= '0;
      err_lat_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      wr_data_q <= wr_data_d;
      byte_en_q <= byte_en_d;
      haddr_q   <= haddr_d;
      err_lat_q <= err_lat_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_data_phase = (state_q == ST_DATA) && is_wr_q;

  // Write data replicated on every lane; only the addressed lane is strobed.
  assign hwdata_o = wr_data_phase ? {LANES{wr_data_q}} : '0;

  always_comb begin
    hwstrb_o = '0;
    if (wr_data_phase) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_sel[l]) begin
          hwstrb_o[l*4 +: 4] = byte_en_q;
        end
      end
    end
  end

  assign htrans_o = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = haddr_q;
  assign hwrite_o = is_wr_q;
  assign hburst_o = '0;       // SINGLE
  assign hprot_o  = 4'b0011;  // data access, privileged
  assign hsize_o  = 3'b010;   // 32-bit word

  assign m_cpuif_req_stall_wr = (state_q != ST_IDLE);
  assign m_cpuif_req_stall_rd = (state_q != ST_IDLE);

  assign m_cpuif_rd_ack  = rd_ack_q;
  assign m_cpuif_rd_err  = rd_ack_q & ack_err_q;
  assign m_cpuif_rd_data = rd_data_q;  // zero except in the rd_ack cycle
  assign m_cpuif_wr_ack  = wr_ack_q;
  assign m_cpuif_wr_err  = wr_ack_q & ack_err_q;

endmodule

// File: tb/tb_ahb_mgr_if.sv
// -----------------------------------------------------------------------------
// tb_ahb_mgr_if
//
// Self-checking bench for ahb_mgr_if (64-bit data, BASE_ADDR 0x1000_0000).
// The bench plays both client and AHB subordinate. Each request is described
// as a transaction (direction, address, data, address/data wait counts, hresp
// pattern, read data); from that description the expected cycle-by-cycle
// outputs follow from the protocol timeline relative to the acceptance cycle.
// -----------------------------------------------------------------------------
module tb_ahb_mgr_if;

  localparam int          DW   = 64;
  localparam int          AW   = 32;
  localparam int          CW   = 12;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] be;
    int          aw;         // address-phase wait states
    int          dw;         // data-phase wait states
    logic [63:0] hrd;        // read data at completion
    logic [31:0] resp_bits;  // bit k = hresp in data-phase cycle k
    int          gap;        // idle cycles before the request is presented
  } txn_t;

  logic          clk = 1'b0;
  logic          hreset_i;
  logic          req, req_is_wr;
  logic [CW-1:0] req_addr;
  logic [31:0]   wr_data, wr_biten;
  logic          stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  logic [31:0]   rd_data;
  logic [AW-1:0] haddr;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic [DW-1:0] hwdata;
  logic [7:0]    hwstrb;
  logic          hwrite;
  logic [DW-1:0] hrdata;
  logic          hready, hresp;

  ahb_mgr_if #(
    .AHB_DATA_WIDTH  (DW),
    .AHB_ADDR_WIDTH  (AW),
    .AHB_BURST_WIDTH (3),
    .CPUIF_ADDR_WIDTH(CW),
    .BASE_ADDR       (BASE)
  ) dut (
    .hclk_i               (clk),
    .hreset_i             (hreset_i),
    .m_cpuif_req          (req),
    .m_cpuif_req_is_wr    (req_is_wr),
    .m_cpuif_addr         (req_addr),
    .m_cpuif_wr_data      (wr_data),
    .m_cpuif_wr_biten     (wr_biten),
    .m_cpuif_req_stall_wr (stall_wr),
    .m_cpuif_req_stall_rd (stall_rd),
    .m_cpuif_rd_ack       (rd_ack),
    .m_cpuif_rd_err       (rd_err),
    .m_cpuif_rd_data      (rd_data),
    .m_cpuif_wr_ack       (wr_ack),
    .m_cpuif_wr_err       (wr_err),
    .haddr_o              (haddr),
    .hburst_o             (hburst),
    .hprot_o              (hprot),
    .hsize_o              (hsize),
    .htrans_o             (htrans),
    .hwdata_o             (hwdata),
    .hwstrb_o             (hwstrb),
    .hwrite_o             (hwrite),
    .hrdata_i             (hrdata),
    .hready_i             (hready),
    .hresp_i              (hresp)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  // Expected outputs for the current cycle
  logic        exp_stall, exp_chk_addr, exp_chk_data, exp_zero, exp_hwrite;
  logic [1:0]  exp_htrans;
  logic [31:0] exp_haddr;
  logic [63:0] exp_hwdata;
  logic [7:0]  exp_hwstrb;
  // Completion owed in the next checked cycle
  logic        pend_valid = 1'b0, pend_wr = 1'b0, pend_err = 1'b0;
  logic [31:0] pend_rdata = '0;
  // Observations used by the literal checks of the directed tests
  int          obs_ack_rel;
  logic        obs_err, obs_nonseq;
  logic [31:0] obs_rd_data, obs_haddr;
  logic [63:0] obs_hwdata;
  logic [7:0]  obs_hwstrb;

  txn_t txq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Model helpers: lane from address arithmetic, strobes from enabled bytes.
  function automatic int model_lane(input logic [31:0] ha);
    return int'((ha / 4) % (DW / 32));
  endfunction

  function automatic logic [7:0] model_strb(input logic [31:0] ha, input logic [31:0] be);
    logic [7:0] s = '0;
    for (int b = 0; b < 4; b++) begin
      if (((be >> (8 * b)) & 32'hFF) != 0) s = s | (8'd1 << (model_lane(ha) * 4 + b));
    end
    return s;
  endfunction

  task automatic set_exp_idle();
    exp_stall = 1'b0; exp_htrans = 2'b00; exp_chk_addr = 1'b0;
    exp_chk_data = 1'b0; exp_zero = 1'b0;
  endtask

  task automatic drive_idle();
    req = 1'b0; req_is_wr = 1'($urandom_range(0, 1));
    req_addr = 12'($urandom); wr_data = $urandom; wr_biten = $urandom;
    hready = 1'($urandom_range(0, 1)); hresp = 1'($urandom_range(0, 1));
    hrdata = {$urandom, $urandom};
  endtask

  task automatic present(input txn_t t);
    req = 1'b1; req_is_wr = t.is_wr; req_addr = t.addr;
    wr_data = t.wd; wr_biten = t.be;
  endtask

  // Called at posedge+1 with inputs set; compares at negedge, returns at
  // the following posedge+1.
  task automatic step();
    logic        e_rd_ack, e_wr_ack;
    logic [31:0] e_rdata;
    @(negedge clk);
    e_rd_ack = pend_valid && !pend_wr;
    e_wr_ack = pend_valid && pend_wr;
    e_rdata  = e_rd_ack ? pend_rdata : 32'h0;
    check("stall_wr", 64'(stall_wr), 64'(exp_stall));
    check("stall_rd", 64'(stall_rd), 64'(exp_stall));
    check("htrans",   64'(htrans),   64'(exp_htrans));
    check("rd_ack",   64'(rd_ack),   64'(e_rd_ack));
    check("wr_ack",   64'(wr_ack),   64'(e_wr_ack));
    check("rd_err",   64'(rd_err),   64'(e_rd_ack && pend_err));
    check("wr_err",   64'(wr_err),   64'(e_wr_ack && pend_err));
    check("rd_data",  64'(rd_data),  64'(e_rdata));
    check("hburst",   64'(hburst),   64'(3'b000));
    check("hprot",    64'(hprot),    64'(4'b0011));
    check("hsize",    64'(hsize),    64'(3'b010));
    if (exp_chk_addr) begin
      check("haddr",  64'(haddr),  64'(exp_haddr));
      check("hwrite", 64'(hwrite), 64'(exp_hwrite));
      obs_haddr = haddr;
    end
    if (exp_chk_data) begin
      check("hwdata", hwdata,      exp_hwdata);
      check("hwstrb", 64'(hwstrb), 64'(exp_hwstrb));
      obs_hwdata = hwdata; obs_hwstrb = hwstrb;
    end
    if (exp_zero) begin
      check("rst_haddr",  64'(haddr),  64'h0);
      check("rst_hwrite", 64'(hwrite), 64'h0);
      check("rst_hwdata", hwdata,      64'h0);
      check("rst_hwstrb", 64'(hwstrb), 64'h0);
    end
    if (rd_ack || wr_ack) begin
      obs_ack_rel = cyc - acc_cyc; obs_rd_data = rd_data; obs_err = rd_err | wr_err;
    end
    if (htrans == 2'b10) obs_nonseq = 1'b1;
    pend_valid = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Runs every queued transaction back to back, then one drain cycle.
  task automatic run_queue();
    for (int i = 0; i < txq.size(); i++) begin
      txn_t        t;
      bit          hold_next, mis, err;
      int          done_rel, k;
      logic [31:0] ha;
      t         = txq[i];
      hold_next = (i + 1 < txq.size()) && (txq[i+1].gap == 0);
      mis       = (t.addr % 4) != 0;
      ha        = BASE + 32'(t.addr);
      done_rel  = mis ? 1 : 3 + t.aw + t.dw;
      for (int g = 0; g < t.gap; g++) begin
        drive_idle(); set_exp_idle(); step();
      end
      drive_idle(); present(t); set_exp_idle();
      step();
      acc_cyc = cyc - 1;
      for (int rel = 1; rel < done_rel; rel++) begin
        drive_idle();
        if (hold_next) present(txq[i+1]);
        set_exp_idle();
        exp_stall = 1'b1;
        if (rel <= 1 + t.aw) begin
          exp_htrans = 2'b10; exp_chk_addr = 1'b1;
          exp_haddr = ha; exp_hwrite = t.is_wr;
          hready = (rel == 1 + t.aw); hresp = 1'b0;
        end else begin
          k = rel - 2 - t.aw;
          exp_chk_data = 1'b1;
          exp_hwdata = t.is_wr ? {2{t.wd}} : 64'h0;
          exp_hwstrb = t.is_wr ? model_strb(ha, t.be) : 8'h0;
          hready = (k == t.dw); hresp = t.resp_bits[k];
          if (k == t.dw) hrdata = t.hrd;
        end
        step();
      end
      err = mis;
      if (!mis) for (int j = 0; j <= t.dw; j++) err = err | t.resp_bits[j];
      pend_valid = 1'b1; pend_wr = t.is_wr; pend_err = err;
      pend_rdata = (mis || t.is_wr) ? 32'h0 : 32'(t.hrd >> (model_lane(ha) * 32));
    end
    drive_idle(); set_exp_idle(); step();
    txq.delete();
  endtask

  function automatic txn_t mk(input bit w, input logic [11:0] a, input logic [31:0] d,
                              input logic [31:0] be, input int aw, input int dw,
                              input logic [63:0] hrd, input logic [31:0] rb, input int gap);
    txn_t t;
    t.is_wr = w; t.addr = a; t.wd = d; t.be = be; t.aw = aw; t.dw = dw;
    t.hrd = hrd; t.resp_bits = rb; t.gap = gap;
    return t;
  endfunction

  initial begin
    hreset_i = 1'b1;
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    set_exp_idle(); exp_zero = 1'b1;
    step();
    hreset_i = 1'b0;
    drive_idle(); set_exp_idle(); step();

    // 1: write 0x104, zero waits
    obs_ack_rel = -1;
    txq.push_back(mk(1, 12'h104, 32'hA5A5_1234, 32'hFFFF_FFFF, 0, 0, 64'h0, 0, 0));
    run_queue();
    check("t1_haddr",  64'(obs_haddr),  64'h1000_0104);
    check("t1_hwdata", obs_hwdata,      64'hA5A51234_A5A51234);
    check("t1_hwstrb", 64'(obs_hwstrb), 64'hF0);
    check("t1_ack_at", 64'(obs_ack_rel), 64'd3);
    check("t1_err",    64'(obs_err),    64'd0);

    // 2: read 0x8 with 2 address and 3 data wait states
    obs_ack_rel = -1;
    txq.push_back(mk(0, 12'h008, 0, 0, 2, 3, 64'hDEAD_BEEF_0BAD_F00D, 0, 1));
    run_queue();
    check("t2_rd_data", 64'(obs_rd_data), 64'h0BAD_F00D);
    check("t2_ack_at",  64'(obs_ack_rel), 64'd8);

    // 3: write 0x10 with the two-cycle error response
    obs_ack_rel = -1;
    txq.push_back(mk(1, 12'h010, 32'h1111_2222, 32'h0000_FF00, 0, 1, 64'h0, 32'b11, 0));
    run_queue();
    check("t3_err",    64'(obs_err),     64'd1);
    check("t3_ack_at", 64'(obs_ack_rel), 64'd4);

    // 4: misaligned read never reaches the bus
    obs_ack_rel = -1; obs_nonseq = 1'b0;
    txq.push_back(mk(0, 12'h006, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0));
    run_queue();
    check("t4_nonseq",  64'(obs_nonseq),  64'd0);
    check("t4_err",     64'(obs_err),     64'd1);
    check("t4_rd_data", 64'(obs_rd_data), 64'd0);
    check("t4_ack_at",  64'(obs_ack_rel), 64'd1);

    // 5: back-to-back write then read with req held
    obs_ack_rel = -1;
    txq.push_back(mk(1, 12'h200, 32'hCAFE_0001, 32'h0000_00FF, 1, 0, 64'h0, 0, 0));
    txq.push_back(mk(0, 12'h204, 0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0));
    run_queue();
    check("t5_rd_data", 64'(obs_rd_data), 64'h1234_5678);
    check("t5_ack_at",  64'(obs_ack_rel), 64'd4);

    // 6: reset during a stalled data phase
    obs_ack_rel = -1;
    drive_idle();
    present(mk(1, 12'h020, 32'h5555_AAAA, 32'hFFFF_FFFF, 0, 0, 64'h0, 0, 0));
    set_exp_idle(); step();
    acc_cyc = cyc - 1;
    drive_idle(); hready = 1'b1; hresp = 1'b0; set_exp_idle();
    exp_stall = 1'b1; exp_htrans = 2'b10; exp_chk_addr = 1'b1;
    exp_haddr = 32'h1000_0020; exp_hwrite = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      drive_idle(); hready = 1'b0; hresp = 1'b0; set_exp_idle();
      exp_stall = 1'b1; exp_chk_data = 1'b1;
      exp_hwdata = 64'h5555AAAA_5555AAAA; exp_hwstrb = 8'h0F;
      hreset_i = (r == 1);
      step();
    end
    hreset_i = 1'b0;
    drive_idle(); hready = 1'b1; set_exp_idle(); exp_zero = 1'b1;
    step();
    for (int r = 0; r < 4; r++) begin
      drive_idle(); hready = 1'b1; set_exp_idle(); step();
    end
    check("t6_no_ack", 64'(obs_ack_rel), 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      txn_t t;
      t.is_wr = 1'($urandom_range(0, 1));
      t.addr  = 12'($urandom) & 12'hFFC;
      if ($urandom_range(0, 7) == 0) t.addr = t.addr | 12'($urandom_range(1, 3));
      t.wd    = $urandom;
      t.be    = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      t.aw    = $urandom_range(0, 3);
      t.dw    = $urandom_range(0, 3);
      t.hrd   = {$urandom, $urandom};
      t.resp_bits = '0;
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < 4; j++) t.resp_bits[j] = ($urandom_range(0, 2) == 0);
      end
      t.gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      txq.push_back(t);
    end
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
